// File: rtl/mmio_fabric_if.sv
// mmio_fabric_if: AXI4-Lite channel bundle between a bus master and the mmio_fabric slave port
interface mmio_fabric_if;
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/mmio_fabric.sv
// mmio_fabric: AXI4-Lite slave to one-hot slot-bus bridge; optional access watchdog via MMIO_TIMEOUT_EN
module mmio_fabric #(
    parameter int                   NUM_SLOTS      = 16,
    parameter int                   REG_ADDR_W     = 5,
    parameter logic [NUM_SLOTS-1:0] SLOT_MASK      = '1,
    parameter int                   TIMEOUT_CYCLES = 256
) (
    input  logic                      aclk,
    input  logic                      rst,
    mmio_fabric_if.slave              s_axi,
    output logic [NUM_SLOTS-1:0]      slot_chip_select,
    output logic                      slot_write,
    output logic                      slot_read,
    output logic [REG_ADDR_W-1:0]     slot_reg_addr,
    output logic [31:0]               slot_wr_data,
    output logic [3:0]                slot_wr_strb,
    input  logic [32*NUM_SLOTS-1:0]   slot_rd_data,
    input  logic [NUM_SLOTS-1:0]      slot_wr_done,
    input  logic [NUM_SLOTS-1:0]      slot_rd_done,
    input  logic [NUM_SLOTS-1:0]      slot_slave_error,
    input  logic [NUM_SLOTS-1:0]      slot_decode_error,
    output logic                      transaction_completed
);
    localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int SLOT_SPAN = 1 << SLOT_W;
    // Slot indices past NUM_SLOTS read as unpopulated.
    localparam logic [SLOT_SPAN-1:0] MASK_EXT = SLOT_SPAN'(SLOT_MASK);
    localparam logic [1:0] OKAY = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    typedef enum logic [2:0] {IDLE, WR_ACC, RD_ACC, WR_RESP, RD_RESP} state_t;

    state_t            state_q;
    logic              last_wr_q;
    logic [SLOT_W-1:0] sel_q;
    logic              bvalid_q;
    logic              rvalid_q;
    logic [1:0]        bresp_q;
    logic [1:0]        rresp_q;
    logic [31:0]       rdata_q;

    logic              wr_req;
    logic              rd_req;
    logic              wr_win;
    logic              rd_win;
    logic [31:0]       acc_addr;
    logic [SLOT_W-1:0] acc_slot;
    logic              acc_mapped;
    logic              acc_done;
    logic              acc_slverr;
    logic              acc_decerr;
    logic [1:0]        acc_resp;
    logic [31:0]       sel_rdata;
    logic              timeout;
    logic              unused_bits;

`ifdef MMIO_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q;

    // watchdog: counts cycles spent waiting on a slot, restarts with every access
    always_ff @(posedge aclk) begin
        if (rst || !(state_q inside {WR_ACC, RD_ACC})) cnt_q <= '0;
        else cnt_q <= cnt_q + 1'b1;
    end

    assign timeout = cnt_q == CNT_W'(TIMEOUT_CYCLES - 1);
`else
    assign timeout = 1'b0;
`endif

    // arbitration, decode of the winning request and completion from the selected slot
    always_comb begin
        wr_req     = state_q == IDLE && s_axi.awvalid && s_axi.wvalid;
        rd_req     = state_q == IDLE && s_axi.arvalid;
        wr_win     = wr_req && !(rd_req && last_wr_q);
        rd_win     = rd_req && !wr_win;
        acc_addr   = wr_win ? s_axi.awaddr : s_axi.araddr;
        acc_slot   = acc_addr[REG_ADDR_W+2 +: SLOT_W];
        acc_mapped = MASK_EXT[acc_slot];
        acc_done   = |(slot_chip_select & (state_q == WR_ACC ? slot_wr_done : slot_rd_done));
        acc_slverr = |(slot_chip_select & slot_slave_error);
        acc_decerr = |(slot_chip_select & slot_decode_error);
        acc_resp   = !acc_done ? SLVERR : acc_slverr ? SLVERR : acc_decerr ? DECERR : OKAY;
        sel_rdata  = slot_rd_data[32*sel_q +: 32];
    end

    assign s_axi.awready = wr_win;
    assign s_axi.wready  = wr_win;
    assign s_axi.arready = rd_win;
    assign s_axi.bvalid  = bvalid_q;
    assign s_axi.bresp   = bresp_q;
    assign s_axi.rvalid  = rvalid_q;
    assign s_axi.rresp   = rresp_q;
    assign s_axi.rdata   = rdata_q;
    assign unused_bits   = ^{s_axi.awprot, s_axi.arprot, acc_addr};

    // access FSM: accept one request, drive the slot until done, then hold the response
    always_ff @(posedge aclk) begin
        if (rst) begin
            state_q               <= IDLE;
            last_wr_q             <= 1'b0;
            sel_q                 <= '0;
            slot_chip_select      <= '0;
            slot_write            <= 1'b0;
            slot_read             <= 1'b0;
            slot_reg_addr         <= '0;
            slot_wr_data          <= '0;
            slot_wr_strb          <= '0;
            bvalid_q              <= 1'b0;
            bresp_q               <= OKAY;
            rvalid_q              <= 1'b0;
            rresp_q               <= OKAY;
            rdata_q               <= '0;
            transaction_completed <= 1'b0;
        end else begin
            transaction_completed <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (wr_win || rd_win) begin
                        last_wr_q     <= wr_win;
                        sel_q         <= acc_slot;
                        slot_reg_addr <= acc_addr[2 +: REG_ADDR_W];
                    end
                    if (wr_win) begin
                        slot_wr_data <= s_axi.wdata;
                        slot_wr_strb <= s_axi.wstrb;
                        bresp_q      <= acc_mapped ? OKAY : DECERR;
                        if (!acc_mapped || s_axi.wstrb == '0) begin
                            state_q  <= WR_RESP;
                            bvalid_q <= 1'b1;
                        end else begin
                            state_q          <= WR_ACC;
                            slot_write       <= 1'b1;
                            slot_chip_select <= NUM_SLOTS'(1) << acc_slot;
                        end
                    end else if (rd_win) begin
                        rresp_q <= DECERR;
                        rdata_q <= '0;
                        if (!acc_mapped) begin
                            state_q  <= RD_RESP;
                            rvalid_q <= 1'b1;
                        end else begin
                            state_q          <= RD_ACC;
                            slot_read        <= 1'b1;
                            slot_chip_select <= NUM_SLOTS'(1) << acc_slot;
                        end
                    end
                end
                WR_ACC, RD_ACC: begin
                    if (acc_done || timeout) begin
                        slot_chip_select      <= '0;
                        slot_write            <= 1'b0;
                        slot_read             <= 1'b0;
                        transaction_completed <= 1'b1;
                        if (state_q == WR_ACC) begin
                            state_q  <= WR_RESP;
                            bvalid_q <= 1'b1;
                            bresp_q  <= acc_resp;
                        end else begin
                            state_q  <= RD_RESP;
                            rvalid_q <= 1'b1;
                            rresp_q  <= acc_resp;
                            rdata_q  <= acc_done ? sel_rdata : '0;
                        end
                    end
                end
                WR_RESP: begin
                    if (s_axi.bready) begin
                        bvalid_q <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                RD_RESP: begin
                    if (s_axi.rready) begin
                        rvalid_q <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
